// File: rtl/c_or.sv
// c_or: parameterised bitwise two-input OR primitive.
//   y         : combinational a | b (no clock or reset dependency)
//   y_q       : registered a | b, loaded only when in_valid is high
//   y_q_valid : y_q was loaded on the last edge
//   any_q     : reduction OR of y_q
//   any_rise  : one-cycle registered pulse after any_q goes 0 -> 1
// Optional build macro C_OR_STATS_EN adds the saturating activity counters
// hi_cnt / rise_cnt and their synchronous clear clr_stats.
module c_or #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_q_valid,
  output logic             any_q,
  output logic             any_rise
`ifdef C_OR_STATS_EN
  ,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] rise_cnt
`endif
);

  // Reject parameter values the lanes and counters cannot support.
  if (WIDTH < 1 || CNT_W < 2) begin : g_bad_param
    $error("c_or: WIDTH must be >= 1 and CNT_W must be >= 2");
  end

  logic [WIDTH-1:0] or_s;
  logic [WIDTH-1:0] y_q_r;
  logic             y_q_valid_r;
  logic             any_s;
  logic             any_hist_r;
  logic             any_rise_r;
  logic             rise_cond_s;

  // Lane-wise OR, also the source of the zero-latency output.
  assign or_s = a | b;
  assign y    = or_s;

  // Activity flag and rising-edge condition derived from the registered result.
  assign any_s       = |y_q_r;
  assign rise_cond_s = any_s & ~any_hist_r;

  assign y_q       = y_q_r;
  assign y_q_valid = y_q_valid_r;
  assign any_q     = any_s;
  assign any_rise  = any_rise_r;

  // Registered result path: load on in_valid, otherwise hold the data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r       <= {WIDTH{1'b0}};
      y_q_valid_r <= 1'b0;
    end else if (in_valid) begin
      y_q_r       <= or_s;
      y_q_valid_r <= 1'b1;
    end else begin
      y_q_r       <= y_q_r;
      y_q_valid_r <= 1'b0;
    end
  end

  // History of any_q and the one-cycle rise pulse built from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_hist_r <= 1'b0;
      any_rise_r <= 1'b0;
    end else begin
      any_hist_r <= any_s;
      any_rise_r <= rise_cond_s;
    end
  end

`ifdef C_OR_STATS_EN
  logic [CNT_W-1:0] hi_cnt_r;
  logic [CNT_W-1:0] rise_cnt_r;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // Activity counters; a clear wins over an increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_r   <= {CNT_W{1'b0}};
      rise_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_stats) begin
      hi_cnt_r   <= {CNT_W{1'b0}};
      rise_cnt_r <= {CNT_W{1'b0}};
    end else begin
      hi_cnt_r   <= any_s ? sat_inc(hi_cnt_r) : hi_cnt_r;
      rise_cnt_r <= rise_cond_s ? sat_inc(rise_cnt_r) : rise_cnt_r;
    end
  end

  assign hi_cnt   = hi_cnt_r;
  assign rise_cnt = rise_cnt_r;
`endif

endmodule

// File: tb/tb_c_or.sv
// Directed bench for c_or: a WIDTH=1 instance (CNT_W=2 for the counter
// saturation checks when C_OR_STATS_EN is defined) and a WIDTH=4 instance.
module tb_c_or;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, v1;
  logic       y1, y_q1, vq1, any1, rise1;
  logic [3:0] a4, b4;
  logic       v4;
  logic [3:0] y4, y_q4;
  logic       vq4, any4, rise4;
`ifdef C_OR_STATS_EN
  logic       clr1, clr4;
  logic [1:0] hi1, rc1;
  logic [15:0] hi4, rc4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  c_or #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .y(y1), .y_q(y_q1), .y_q_valid(vq1), .any_q(any1), .any_rise(rise1)
`ifdef C_OR_STATS_EN
    , .clr_stats(clr1), .hi_cnt(hi1), .rise_cnt(rc1)
`endif
  );

  c_or #(.WIDTH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4),
    .y(y4), .y_q(y_q4), .y_q_valid(vq4), .any_q(any4), .any_rise(rise4)
`ifdef C_OR_STATS_EN
    , .clr_stats(clr4), .hi_cnt(hi4), .rise_cnt(rc4)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] ta, tb, ty;

  initial begin
    ta = 5'b01010;  // vector i uses bit i: (a,b) = 00,11,01,10,00
    tb = 5'b00110;
    ty = 5'b01110;
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    a4 = 4'd0; b4 = 4'd0; v4 = 1'b0;
`ifdef C_OR_STATS_EN
    clr1 = 1'b0; clr4 = 1'b0;
`endif
    // Reset state, before any clock edge
    #2;
    chk("rst_y",        16'(y1),    16'd1);
    chk("rst_y_q",      16'(y_q1),  16'd0);
    chk("rst_y_q_valid",16'(vq1),   16'd0);
    chk("rst_any_rise", 16'(rise1), 16'd0);

    // Release reset between edges (next edge at 25)
    #20;
    rst_n = 1'b1;
    tick();
    chk("post_rst_y_q",      16'(y_q1),  16'd1);
    chk("post_rst_valid",    16'(vq1),   16'd1);
    chk("post_rst_rise0",    16'(rise1), 16'd0);
    tick();
    chk("post_rst_rise1",    16'(rise1), 16'd1);
    tick();
    chk("post_rst_rise2",    16'(rise1), 16'd0);

    // WIDTH=1 truth-table walk through the registered path
    for (int i = 0; i < 5; i++) begin
      a1 = ta[i]; b1 = tb[i];
      #1;
      chk($sformatf("tt_y_%0d", i), 16'(y1), 16'(ty[i]));
      tick();
      chk($sformatf("tt_y_q_%0d", i), 16'(y_q1), 16'(ty[i]));
      chk($sformatf("tt_valid_%0d", i), 16'(vq1), 16'd1);
    end

    // Async reset pulse between edges while y_q=1
    a1 = 1'b1; b1 = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y_q",   16'(y_q1), 16'd0);
    chk("mid_rst_valid", 16'(vq1),  16'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mid_rst_reload", 16'(y_q1), 16'd1);
    tick();
    chk("mid_rst_rise",   16'(rise1), 16'd1);

    // WIDTH=4 load then hold
    a4 = 4'b1010; b4 = 4'b0110; v4 = 1'b1;
    tick();
    chk("w4_y_q",  16'(y_q4), 16'h000e);
    chk("w4_any",  16'(any4), 16'd1);
    a4 = 4'd0; b4 = 4'd0; v4 = 1'b0;
    #1;
    chk("w4_y_zero", 16'(y4), 16'd0);
    tick();
    chk("w4_hold_y_q",  16'(y_q4), 16'h000e);
    chk("w4_hold_valid",16'(vq4),  16'd0);

`ifdef C_OR_STATS_EN
    // Fresh start for the counters
    a1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #2;
    chk("st_rst_hi",   16'(hi1), 16'd0);
    rst_n = 1'b1;
    tick();
    a1 = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("st_hi_sat",   16'(hi1), 16'd3);
    chk("st_rise_one", 16'(rc1), 16'd1);
    for (int i = 0; i < 4; i++) begin
      a1 = 1'b0; tick(); tick();
      a1 = 1'b1; tick(); tick();
    end
    chk("st_rise_sat", 16'(rc1), 16'd3);

    // Clear on a cycle with any_q=1 wins over the increment
    chk("st_any_pre_clr", 16'(any1), 16'd1);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("st_clr_hi",   16'(hi1), 16'd0);
    chk("st_clr_rise", 16'(rc1), 16'd0);
    tick();
    chk("st_after_clr_hi",   16'(hi1), 16'd1);
    chk("st_after_clr_rise", 16'(rc1), 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
